// File: rtl/imem_stream_loader.sv
// Byte-stream loader for the instruction memory. It unpacks a framed stream into big-endian words,
// writes them sequentially, and keeps the CPU in reset until the frame checksum matches.
//
// state  | meaning
// IDLE   | discard bytes until the sync marker arrives
// CNT_HI | capture word count bits [15:8]
// CNT_LO | capture word count bits [7:0], then range-check it
// DATA   | assemble payload words and write them
// CHK    | compare the received checksum byte
// DONE   | frame loaded, CPU released
// ERR    | frame rejected, CPU held
module imem_stream_loader #(
  parameter int         ADDR_WIDTH = 8,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  Clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, DATA, CHK, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_N = 17'd1 << ADDR_WIDTH;

  state_t              state;
  logic [15:0]         n;
  logic [ADDR_WIDTH:0] widx;
  logic [1:0]          bidx;
  logic [23:0]         word;
  logic [7:0]          csum;

  logic        accept;
  logic [16:0] n_full;
  logic [16:0] widx_inc;

  assign accept   = in_valid & in_ready;
  assign n_full   = {1'b0, n[15:8], in_data};
  assign widx_inc = 17'(widx) + 17'd1;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      n          <= '0;
      widx       <= '0;
      bidx       <= '0;
      word       <= '0;
      csum       <= '0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept && in_data == SYNC_BYTE) state <= CNT_HI;
        end
        CNT_HI: begin
          if (accept) begin
            n[15:8] <= in_data;
            state   <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            n[7:0] <= in_data;
            widx   <= '0;
            bidx   <= '0;
            csum   <= '0;
            if (n_full > MAX_N) begin
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if (n_full == 17'd0) begin
              state <= CHK;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word <= {word[15:0], in_data};
            csum <= csum ^ in_data;
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= widx[ADDR_WIDTH-1:0];
              imem_wdata <= {word, in_data};
              widx       <= widx + 1'b1;
              // widx is one bit wider than the address so a full-depth load still terminates
              if (widx_inc == {1'b0, n}) state <= CHK;
            end
          end
        end
        CHK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (start) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: a table of whole frames plus hand-written
// sequences for the full-depth load, start-during-DATA and mid-frame reset.
module tb_imem_stream_loader;
  localparam int AW = 8;

  logic          Clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          start = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  imem_stream_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .Clk(Clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  int            wr_cyc[$];
  logic [31:0]   words[0:255];

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
  end

  typedef struct {
    string       name;
    bit          noise;
    bit          gaps;
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  chk;
    bit          full;
    logic        exp_done;
    logic        exp_err;
    int          exp_writes;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after the byte was accepted.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 20) check("send_ready_timeout", {31'b0, in_ready}, 32'd1);
    @(negedge Clk);
  endtask

  task automatic put(input logic [7:0] b, input bit gaps);
    send(b);
    if (gaps) begin
      in_valid = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic send_frame(input logic [15:0] n, input int nw, input logic [7:0] chk,
                            input bit gaps, input bit full);
    put(8'hA5, gaps);
    put(n[15:8], gaps);
    put(n[7:0], gaps);
    if (full) begin
      for (int i = 0; i < nw; i++)
        for (int k = 3; k >= 0; k--) put(words[i][8*k +: 8], gaps);
      put(chk, gaps);
    end
    in_valid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic pulse_start_and_check(input string name);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check({name, "_idle_done"},  {31'b0, done},     32'd0);
    check({name, "_idle_error"}, {31'b0, error},    32'd0);
    check({name, "_idle_hold"},  {31'b0, cpu_hold}, 32'd1);
    check({name, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] big_chk;
    int         bad;

    vecs[0] = '{"clean",    0, 0, 16'h0002, 32'h24080005, 32'h0000000C, 8'h25, 1, 1'b1, 1'b0, 2};
    vecs[1] = '{"bad_chk",  0, 0, 16'h0002, 32'h24080005, 32'h0000000C, 8'h26, 1, 1'b0, 1'b1, 2};
    vecs[2] = '{"noise_gap",1, 1, 16'h0002, 32'h24080005, 32'h0000000C, 8'h25, 1, 1'b1, 1'b0, 2};
    vecs[3] = '{"n_zero",   0, 0, 16'h0000, 32'h0,        32'h0,        8'h00, 1, 1'b1, 1'b0, 0};
    vecs[4] = '{"overflow", 0, 0, 16'h0101, 32'h0,        32'h0,        8'h00, 0, 1'b0, 1'b1, 0};
    vecs[5] = '{"one_word", 0, 1, 16'h0001, 32'h12345678, 32'h0,        8'h08, 1, 1'b1, 1'b0, 1};
    vecs[6] = '{"zero_bad", 0, 0, 16'h0000, 32'h0,        32'h0,        8'h01, 1, 1'b0, 1'b1, 0};

    // Reset values while rst is asserted
    #12;
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_we",    {31'b0, imem_we},  32'd0);
    check("rst_addr",  {24'b0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata,        32'd0);
    check("rst_hold",  {31'b0, cpu_hold}, 32'd1);
    check("rst_done",  {31'b0, done},     32'd0);
    check("rst_error", {31'b0, error},    32'd0);
    @(negedge Clk);
    rst = 1'b1;
    @(negedge Clk);
    check("post_rst_ready", {31'b0, in_ready}, 32'd1);

    for (int v = 0; v < 7; v++) begin
      clear_writes();
      words[0] = vecs[v].w0;
      words[1] = vecs[v].w1;
      if (vecs[v].noise) begin
        put(8'h00, vecs[v].gaps);
        put(8'hFF, vecs[v].gaps);
      end
      send_frame(vecs[v].n, int'(vecs[v].n), vecs[v].chk, vecs[v].gaps, vecs[v].full);
      @(negedge Clk);
      check({vecs[v].name, "_done"},   {31'b0, done},     {31'b0, vecs[v].exp_done});
      check({vecs[v].name, "_error"},  {31'b0, error},    {31'b0, vecs[v].exp_err});
      check({vecs[v].name, "_hold"},   {31'b0, cpu_hold}, {31'b0, ~vecs[v].exp_done});
      check({vecs[v].name, "_ready"},  {31'b0, in_ready}, 32'd0);
      check({vecs[v].name, "_nwr"},    wr_addr.size(),    vecs[v].exp_writes);
      for (int i = 0; i < vecs[v].exp_writes && i < wr_addr.size(); i++) begin
        check({vecs[v].name, "_addr"}, {24'b0, wr_addr[i]}, i);
        check({vecs[v].name, "_data"}, wr_data[i], (i == 0) ? vecs[v].w0 : vecs[v].w1);
      end
      if (!vecs[v].gaps && wr_cyc.size() == 2)
        check({vecs[v].name, "_spacing"}, wr_cyc[1] - wr_cyc[0], 32'd4);
      pulse_start_and_check(vecs[v].name);
    end

    // Full-depth load: 256 words, last at address 0xFF
    clear_writes();
    big_chk = 8'h00;
    for (int i = 0; i < 256; i++) begin
      words[i] = {8'(i), ~8'(i), 8'hC3, 8'(i + 1)};
      big_chk = big_chk ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
    end
    send_frame(16'h0100, 256, big_chk, 1'b0, 1'b1);
    check("big_done",  {31'b0, done},     32'd1);
    check("big_nwr",   wr_addr.size(),    32'd256);
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 256; i++)
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== words[i]) bad++;
    check("big_mismatches", bad, 32'd0);
    if (wr_addr.size() > 0) check("big_last_addr", {24'b0, wr_addr[wr_addr.size() - 1]}, 32'hFF);
    pulse_start_and_check("big");

    // start during DATA is ignored
    clear_writes();
    words[0] = 32'h24080005;
    words[1] = 32'h0000000C;
    send(8'hA5); send(8'h00); send(8'h02); send(8'h24); send(8'h08);
    start = 1'b1;
    send(8'h00);
    start = 1'b0;
    send(8'h05); send(8'h00); send(8'h00); send(8'h00); send(8'h0C); send(8'h25);
    in_valid = 1'b0;
    @(negedge Clk);
    check("start_ign_done", {31'b0, done}, 32'd1);
    check("start_ign_nwr",  wr_addr.size(), 32'd2);
    if (wr_data.size() == 2) begin
      check("start_ign_w0", wr_data[0], 32'h24080005);
      check("start_ign_w1", wr_data[1], 32'h0000000C);
    end
    pulse_start_and_check("start_ign");

    // Reset after 5 payload bytes
    clear_writes();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h24); send(8'h08); send(8'h00); send(8'h05); send(8'h00);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_we",    {31'b0, imem_we},  32'd0);
    check("mid_rst_addr",  {24'b0, imem_addr}, 32'd0);
    check("mid_rst_wdata", imem_wdata,        32'd0);
    check("mid_rst_hold",  {31'b0, cpu_hold}, 32'd1);
    repeat (3) @(negedge Clk);
    rst = 1'b1;
    repeat (3) @(negedge Clk);
    check("mid_rst_nwr",   wr_addr.size(),    32'd1);
    check("mid_rst_idle",  {31'b0, in_ready}, 32'd1);
    check("mid_rst_done",  {31'b0, done},     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_stream_loader.md
# imem_stream_loader

Serial-to-word instruction memory writer for the pipelined MIPS datapath. It accepts a framed byte stream from a byte source, such as the UART receiver, through a valid/ready handshake. It assembles big-endian 32-bit words, writes them sequentially into the instruction memory write port, and verifies an XOR checksum. The CPU is held in reset until a frame loads cleanly. It is the writing end of the instruction memory that the fetch stage reads.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory; depth = 2^ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- Clk  in  1  single clock for the whole block.
- rst  in  1  reset, asynchronous, active-low.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte; a transfer occurs on a Clk edge with in_valid & in_ready.
- start  in  1  one-cycle pulse; from DONE or ERR, returns the block to IDLE for a new frame.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  ADDR_WIDTH  word address.
- imem_wdata  out  32  word to write.
- cpu_hold  out  1  drives the CPU reset; 1 = hold.
- done  out  1  frame loaded and checksum matched.
- error  out  1  frame rejected.

## Operation
- Frame format, byte order on the stream:
  - SYNC_BYTE
  - CNT_HI, CNT_LO: N, the 16-bit word count
  - N×4 payload bytes, most significant byte first within each word
  - CHK: XOR of all payload bytes only.
- States: IDLE, CNT_HI, CNT_LO, DATA, CHK, DONE, ERR.
- IDLE: accepted byte == SYNC_BYTE → CNT_HI. Any other byte is discarded and the state stays IDLE.
- CNT_HI: accepted byte → N[15:8]; go to CNT_LO.
- CNT_LO: accepted byte → N[7:0]. Then:
  - full N > 2^ADDR_WIDTH → ERR
  - N == 0 → CHK
  - otherwise → DATA with word index 0, byte index 0, running checksum 0.
- DATA:
  - Each accepted byte shifts into the word register (word = {word[23:0], byte}) and XORs into the checksum.
  - On the 4th byte, issue a write to the current word index and increment it.
  - After word N−1 is written → CHK.
- CHK: accepted byte == running checksum → DONE, else → ERR.
- DONE: done=1, cpu_hold=0, in_ready=0. Stays until start → IDLE.
- ERR: error=1, cpu_hold=1, in_ready=0. Stays until start → IDLE. Memory contents are left partially written.
- start is ignored in all states except DONE and ERR.
- in_ready=1 in IDLE, CNT_HI, CNT_LO, DATA and CHK.
- Word index width is ADDR_WIDTH+1 so that N == 2^ADDR_WIDTH terminates correctly.
- cpu_hold is 1 in every state except DONE.

## Timing
- Reset values (asserted asynchronously, released synchronously to Clk):
  - state=IDLE, in_ready=0 during reset and 1 after
  - imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_hold=1, done=0, error=0.
- All outputs are registered.
- Write latency: imem_we pulses high for exactly one cycle, in the cycle after the edge that accepts the 4th byte of a word. imem_addr and imem_wdata are valid in that same cycle and hold until the next write.
- Back-to-back: with in_valid held high, one byte is accepted per cycle, giving one write every 4 cycles. No bubbles are inserted.
- in_valid low in any state: no state change, and partial-word/checksum state is retained.
- done/error/cpu_hold change in the cycle after the edge that accepts the CHK byte (or the CNT_LO byte, for overflow).
- start in DONE/ERR: in the next cycle the state is IDLE, done=error=0, cpu_hold=1, in_ready=1.
- An rst assertion mid-frame aborts immediately; no further writes occur.

## Test plan
- Clean load: A5 00 02 | 24 08 00 05 | 00 00 00 0C | CHK=0x25, in_valid held high.
  - Expect exactly 2 writes: (addr0, 0x24080005) and (addr1, 0x0000000C), spaced 4 cycles apart.
  - Then done=1, cpu_hold=0.
- Bad checksum: same frame with CHK=0x26.
  - Expect both writes, then error=1, cpu_hold=1, done=0, in_ready=0.
- Noise and gaps: bytes 00 FF, then the frame with in_valid toggling every other cycle.
  - Expect the leading bytes ignored, identical writes/results to the clean-load case, and no write until the 4th byte of each word.
- Boundary counts:
  - N=0 with CHK=00 → done, zero writes.
  - ADDR_WIDTH=8, N=0x0100 → 256 writes, last at addr 0xFF.
  - N=0x0101 → error right after CNT_LO, zero writes.
- Restart and reset: from ERR, pulse start then send the clean frame → done.
  - Separately, assert rst after 5 payload bytes → immediate reset values, exactly 1 write observed.
- start ignored: pulse start during DATA → no effect, frame completes normally.
